// File: rtl/xy2_100_tx_if.sv
// rtl/xy2_100_tx_if.sv - position word handshake between a host and the XY2-100 transmitter
interface xy2_100_tx_if;
   logic [15:0] x_data;
   logic [15:0] y_data;
   logic        data_valid;
   logic        data_ready;

   modport master (output x_data, output y_data, output data_valid, input data_ready);
   modport slave  (input x_data, input y_data, input data_valid, output data_ready);
endinterface

// File: rtl/xy2_100_tx.sv
// rtl/xy2_100_tx.sv - XY2-100 transmitter serialising staged X/Y words into back-to-back 20-bit frames
module xy2_100_tx #(
   parameter int          CLK_DIV   = 10,
   parameter logic [2:0]  CTRL_BITS = 3'b001
) (
   input  logic         clk_ref,
   input  logic         reset,
   input  logic         en,
   xy2_100_tx_if.slave  data_if,
   output logic         xy_clk,
   output logic         xy_sync,
   output logic         xy_x,
   output logic         xy_y,
   output logic         frame_done,
   output logic         underrun,
   output logic         busy
);

   localparam int             DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0]  DIV_MAX  = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0]  DIV_HALF = DW'(CLK_DIV / 2);
   localparam logic [4:0]     LAST_BIT = 5'd19;

   typedef enum logic [0:0] {IDLE, RUN} state_t;

   state_t        state, state_nxt;
   logic [DW-1:0] div_cnt, div_nxt;
   logic [4:0]    bit_idx, bit_nxt;
   logic [19:0]   frame_x, frame_y;
   logic [15:0]   stage_x, stage_y;
   logic          stage_full, stage_full_nxt;
   logic          data_ready_q;
   logic          accept, load;
   logic          xy_clk_nxt, xy_sync_nxt, xy_x_nxt, xy_y_nxt;
   logic          frame_done_nxt, underrun_nxt;

   function automatic logic [19:0] build_frame(input logic [15:0] d);
      build_frame = {CTRL_BITS, d, ^{CTRL_BITS, d}};
   endfunction

   assign accept             = data_if.data_valid & data_ready_q;
   assign data_if.data_ready = data_ready_q;
   assign busy               = (state == RUN);

   // A load can never coincide with an accept, but if it did the new word must stay staged.
   assign stage_full_nxt = (stage_full & ~load) | accept;

   always_comb begin
      state_nxt      = state;
      div_nxt        = div_cnt;
      bit_nxt        = bit_idx;
      load           = 1'b0;
      frame_done_nxt = 1'b0;
      underrun_nxt   = 1'b0;
      xy_clk_nxt     = 1'b0;
      xy_sync_nxt    = 1'b0;
      xy_x_nxt       = 1'b0;
      xy_y_nxt       = 1'b0;
      case (state)
         IDLE: begin
            if (en && stage_full) begin
               load      = 1'b1;
               state_nxt = RUN;
               div_nxt   = '0;
               bit_nxt   = 5'd0;
            end
         end
         RUN: begin
            xy_clk_nxt = (div_cnt < DIV_HALF);
            // Data and sync move only with the rising edge, holding through the falling edge.
            if (div_cnt == '0) begin
               xy_sync_nxt = (bit_idx != LAST_BIT);
               xy_x_nxt    = frame_x[LAST_BIT - bit_idx];
               xy_y_nxt    = frame_y[LAST_BIT - bit_idx];
            end else begin
               xy_sync_nxt = xy_sync;
               xy_x_nxt    = xy_x;
               xy_y_nxt    = xy_y;
            end
            if (div_cnt == DIV_MAX) begin
               div_nxt = '0;
               bit_nxt = (bit_idx == LAST_BIT) ? 5'd0 : bit_idx + 5'd1;
            end else begin
               div_nxt = div_cnt + DW'(1);
            end
            if (div_cnt == DIV_MAX && bit_idx == LAST_BIT) begin
               frame_done_nxt = 1'b1;
               if (!en) begin
                  state_nxt = IDLE;
               end else if (stage_full) begin
                  load = 1'b1;
               end else begin
                  underrun_nxt = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_ref) begin
      if (reset) begin
         state        <= IDLE;
         div_cnt      <= '0;
         bit_idx      <= 5'd0;
         frame_x      <= '0;
         frame_y      <= '0;
         stage_x      <= '0;
         stage_y      <= '0;
         stage_full   <= 1'b0;
         data_ready_q <= 1'b0;
         xy_clk       <= 1'b0;
         xy_sync      <= 1'b0;
         xy_x         <= 1'b0;
         xy_y         <= 1'b0;
         frame_done   <= 1'b0;
         underrun     <= 1'b0;
      end else begin
         state        <= state_nxt;
         div_cnt      <= div_nxt;
         bit_idx      <= bit_nxt;
         stage_full   <= stage_full_nxt;
         data_ready_q <= ~stage_full_nxt;
         if (accept) begin
            stage_x <= data_if.x_data;
            stage_y <= data_if.y_data;
         end
         // Without a load the frame registers keep the last words, which is the underrun repeat.
         if (load) begin
            frame_x <= build_frame(stage_x);
            frame_y <= build_frame(stage_y);
         end
         xy_clk     <= xy_clk_nxt;
         xy_sync    <= xy_sync_nxt;
         xy_x       <= xy_x_nxt;
         xy_y       <= xy_y_nxt;
         frame_done <= frame_done_nxt;
         underrun   <= underrun_nxt;
      end
   end

endmodule
